pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Next-generation hazard/forwarding controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
//  Adds to plain forwarding and load-use detection: a multi-cycle mul/div unit held in E,
//  variable-latency data memory (ready handshake in M), and per-stage stall/flush outputs.
//  Sits beside the datapath; all stage registers take their Stall*/Flush* from this block.
// PARAMETERS
//  REG_ADDR_W  5   register index width; index 0 is hard-wired zero, never forwarded or hazarded
//  MD_LAT      4   mul/div latency in cycles (>=2); instruction occupies E for MD_LAT cycles
//  PERF_W      32  width of performance counters (HAZARD_PERF_EN only)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   synchronous reset, active-low
//  Rs1D,Rs2D   in   REG_ADDR_W  source regs in D
//  Rs1E,Rs2E   in   REG_ADDR_W  source regs in E
//  RdE,RdM,RdW in   REG_ADDR_W  destination regs per stage
//  RegWriteE/M/W in 1  writeback enable per stage
//  ResultSrcE/M/W in 2 result select: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
//  PCSrcE      in   2   00 sequential, 01 branch/jal taken, 10 jalr
//  MdStartE    in   1   instruction in E is mul/div
//  DMemReadyM  in   1   data memory ready; meaningful only when ResultSrcM==01
//  StallF,StallD,StallE,StallM out 1  hold stage register
//  FlushD,FlushE,FlushM,FlushW out 1  insert bubble into stage register
//  ForwardAE,ForwardBE out 2  00 regfile, 10 ALU result M, 01 result W, 11 immediate M
//  MdBusy      out  1   mul/div timer running
// BEHAVIOUR
//  Forwarding (comb, per operand X in {1,2}), first match wins, all require RsXE!=0:
//   RsXE==RdM & RegWriteM & ResultSrcM==11 -> 11; RsXE==RdM & RegWriteM -> 10;
//   RsXE==RdW & RegWriteW -> 01; else 00.
//  MemWait = ResultSrcM==01 & RegWriteM & !DMemReadyM: StallF/D/E/M=1, FlushW=1; highest priority.
//  MdHold = MD FSM in BUSY: StallF/D/E=1, FlushM=1 (bubbles follow mul/div).
//  LoadUse = ResultSrcE==01 & RegWriteE & RdE!=0 & ((Rs1D==RdE)|(Rs2D==RdE)):
//   StallF/D=1, FlushE=1; suppressed while MemWait or MdHold (E already held).
//  Branch: PCSrcE!=00 & !StallE -> FlushD=1, FlushE=1 (both 01 and 10); overrides LoadUse stall.
//  MD FSM (states IDLE, BUSY): IDLE & MdStartE & !MemWait -> BUSY, counter<=MD_LAT-2.
//   BUSY: counter decrements each cycle without MemWait; frozen during MemWait.
//   BUSY & counter==0 & !MemWait -> IDLE; that cycle MdHold=0 so E advances.
//   Back-to-back mul/div: new MdStartE seen in IDLE the cycle after release -> BUSY again.
//  Counter width clog2(MD_LAT); no wrap possible (counter loads only in IDLE).
//  Reset (rst==0 at edge): FSM IDLE, counter 0, perf counters 0; while rst==0 all outputs
//   forced 0. Reset during BUSY abandons the operation; no stall afterwards.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs PerfStallCnt, PerfFlushCnt (PERF_W each).
//   PerfStallCnt +1 every cycle StallF=1; PerfFlushCnt +1 every cycle FlushD|FlushE=1;
//   both saturate at all-ones. Undefined: ports and registers absent, behaviour otherwise same.
// STRUCTURE
//  hazard_pkg: ResultSrc encodings (RS_ALU/RS_LOAD/RS_PC4/RS_IMM), ForwardSel encodings,
//   PCSrc encodings, MD FSM state enum.
//  Sub-module md_latency_timer: FSM+counter; inputs start, freeze; outputs busy.
//  Top: forwarding muxes, hazard priority logic, optional perf counters.
// TESTING
//  1 RdM=5,RegWriteM=1,ResultSrcM=00,Rs1E=5,RdW=5,RegWriteW=1 -> ForwardAE=10; Rs1E=0 -> 00.
//  2 RdM=7,ResultSrcM=11,RegWriteM=1,Rs2E=7 -> ForwardBE=11; RdM=3,RdW=7,Rs2E=7 -> 01.
//  3 load RdE=4,Rs2D=4 -> StallF/D=1,FlushE=1 one cycle; with RdE=0 -> no stall.
//  4 MdStartE=1,MD_LAT=4 -> StallE=1 for 3 cycles, released 4th; MemWait 2 cycles mid-op
//    -> StallE for 5 cycles total, MdBusy held.
//  5 DMemReadyM=0 for 3 cycles with load in M and PCSrcE=01 -> Stall F..M=1, FlushW=1,
//    FlushD=0; ready=1 -> FlushD=FlushE=1 that cycle.
//  6 rst=0 during BUSY -> next cycle all outputs 0, MdBusy=0; HAZARD_PERF_EN: counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
//   result_src_e : writeback result select carried with each instruction
//   fwd_sel_e    : E-stage operand forwarding select
//   pc_src_e     : next-PC select resolved in E
//   md_state_e   : mul/div latency timer state
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RS_ALU  = 2'b00,
        RS_LOAD = 2'b01,
        RS_PC4  = 2'b10,
        RS_IMM  = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_W     = 2'b01,
        FWD_M_ALU = 2'b10,
        FWD_M_IMM = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_BR   = 2'b01,
        PC_JALR = 2'b10
    } pc_src_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-stage information seen by the hazard controller and the
// stall/flush/forward controls it returns.
//   master : datapath side (drives register indices, enables, selects, ready)
//   slave  : hazard controller side (drives Stall*/Flush*/Forward*/MdBusy)
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E;
    logic [REG_ADDR_W-1:0] RdE, RdM, RdW;
    logic                  RegWriteE, RegWriteM, RegWriteW;
    logic [1:0]            ResultSrcE, ResultSrcM, ResultSrcW;
    logic [1:0]            PCSrcE;
    logic                  MdStartE;
    logic                  DMemReadyM;

    logic                  StallF, StallD, StallE, StallM;
    logic                  FlushD, FlushE, FlushM, FlushW;
    logic [1:0]            ForwardAE, ForwardBE;
    logic                  MdBusy;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteE, RegWriteM, RegWriteW,
        output ResultSrcE, ResultSrcM, ResultSrcW,
        output PCSrcE, MdStartE, DMemReadyM,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushM, FlushW,
        input  ForwardAE, ForwardBE, MdBusy
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteE, RegWriteM, RegWriteW,
        input  ResultSrcE, ResultSrcM, ResultSrcW,
        input  PCSrcE, MdStartE, DMemReadyM,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushM, FlushW,
        output ForwardAE, ForwardBE, MdBusy
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_latency_timer.sv
// Mul/div latency timer: tracks how long a multi-cycle operation stays in E.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  synchronous reset, active-low
//   start  in  instruction in E is mul/div
//   freeze in  memory wait: hold the count and state
//   busy   out timer running (registered)
//   last   out count has reached zero (final cycle of the operation when busy)
module md_latency_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic freeze,
    output logic busy,
    output logic last
);
    localparam int unsigned CntW = $clog2(MD_LAT);
    // The start cycle itself spends one cycle in E and the release cycle another.
    localparam logic [CntW-1:0] CntLoad = CntW'(MD_LAT - 2);

    md_state_e       state;
    logic [CntW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                MD_IDLE: begin
                    if (start && !freeze) begin
                        state <= MD_BUSY;
                        cnt   <= CntLoad;
                        busy  <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (!freeze) begin
                        if (cnt == '0) begin
                            state <= MD_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - CntW'(1);
                        end
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage F/D/E/M/W pipeline.
// Ports:
//   clk  in     clock, rising edge
//   rst  in     synchronous reset, active-low; all outputs forced low while asserted
//   bus  slave  stage indices/enables/selects in; Stall*/Flush*/Forward*/MdBusy out
//   PerfStallCnt, PerfFlushCnt out (HAZARD_PERF_EN only) saturating event counters
// Build option: define HAZARD_PERF_EN to add the performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MD_LAT     = 4,
    parameter int unsigned PERF_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]   PerfStallCnt,
    output logic [PERF_W-1:0]   PerfFlushCnt
`endif
);

    logic mem_wait, md_hold, load_use, branch_req;
    logic md_busy, md_last;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_m, flush_w;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic [1:0] fwd_pick(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  we_m,
        input logic [1:0]            src_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs != '0) begin
            if (rs == rd_m && we_m) begin
                sel = (src_m == RS_IMM) ? FWD_M_IMM : FWD_M_ALU;
            end else if (rs == rd_w && we_w) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    assign mem_wait   = (bus.ResultSrcM == RS_LOAD) && bus.RegWriteM && !bus.DMemReadyM;
    assign load_use   = (bus.ResultSrcE == RS_LOAD) && bus.RegWriteE && (bus.RdE != '0) &&
                        ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));
    assign branch_req = (bus.PCSrcE != PC_SEQ);

    md_latency_timer #(
        .MD_LAT (MD_LAT)
    ) u_md_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (bus.MdStartE),
        .freeze (mem_wait),
        .busy   (md_busy),
        .last   (md_last)
    );

    // E is held from the cycle the mul/div is first seen until the timer's last cycle.
    assign md_hold = (!md_busy && bus.MdStartE && !mem_wait) || (md_busy && !md_last);

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        fwd_a   = FWD_RF;
        fwd_b   = FWD_RF;
        if (rst) begin
            fwd_a = fwd_pick(bus.Rs1E, bus.RdM, bus.RegWriteM, bus.ResultSrcM,
                             bus.RdW, bus.RegWriteW);
            fwd_b = fwd_pick(bus.Rs2E, bus.RdM, bus.RegWriteM, bus.ResultSrcM,
                             bus.RdW, bus.RegWriteW);
            if (mem_wait) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (md_hold) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else begin
                // E advances here, so a resolved branch kills D/E and overrides load-use.
                flush_d = branch_req;
                flush_e = branch_req || load_use;
                stall_f = load_use && !branch_req;
                stall_d = load_use && !branch_req;
            end
        end
    end

    assign bus.StallF    = stall_f;
    assign bus.StallD    = stall_d;
    assign bus.StallE    = stall_e;
    assign bus.StallM    = stall_m;
    assign bus.FlushD    = flush_d;
    assign bus.FlushE    = flush_e;
    assign bus.FlushM    = flush_m;
    assign bus.FlushW    = flush_w;
    assign bus.ForwardAE = fwd_a;
    assign bus.ForwardBE = fwd_b;
    assign bus.MdBusy    = rst && md_busy;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            PerfStallCnt <= '0;
            PerfFlushCnt <= '0;
        end else begin
            if (stall_f && !(&PerfStallCnt)) begin
                PerfStallCnt <= PerfStallCnt + PERF_W'(1);
            end
            if ((flush_d || flush_e) && !(&PerfFlushCnt)) begin
                PerfFlushCnt <= PerfFlushCnt + PERF_W'(1);
            end
        end
    end
`else
    logic unused_perf_w;
    assign unused_perf_w = ^PERF_W;
`endif

endmodule
